uart_baud_gen: RTL and testbench

Parametrised UART baud tick generator, successor to the fixed-divisor baud clock. It produces single-cycle oversample ticks and bit ticks from the system clock, with an optional fractional divisor for low baud error. The divisor is programmable at run time and applied glitch-free on a period boundary. It feeds the UART RX sampler (os_tick), the TX shifter (bit_tick), and legacy consumers (baud_clk).

---
 rtl/uart_pkg.sv | 19 +
 rtl/baud_frac_acc.sv | 20 ++
 rtl/uart_baud_gen.sv | 93 +++++++++
 tb/tb_uart_baud_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, divisor pair type and default divisor calculation for the UART baud generator.
package uart_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DIV_MIN = 2;
  typedef struct packed {
    logic [DEF_CNT_W-1:0]  div_int;
    logic [DEF_FRAC_W-1:0] div_frac;
  } div_pair_t;
  function automatic div_pair_t calc_div(longint clk_hz, longint baud, longint os);
    div_pair_t d;
    longint q;
    q = (clk_hz << DEF_FRAC_W) / (baud * os);
    d.div_int = DEF_CNT_W'(q >> DEF_FRAC_W);
    d.div_frac = DEF_FRAC_W'(q);
    return d;
  endfunction
  localparam div_pair_t DEF_DIV = calc_div(50_000_000, 9600, 16);
endpackage

// File: rtl/baud_frac_acc.sv
// baud_frac_acc: fractional phase accumulator; o_carry stretches the next period by one cycle.
module baud_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_carry
);
  logic [FRAC_W-1:0] r_acc;
  always_ff @(posedge clk)
    if (rst || i_clr) begin
      r_acc <= '0;
      o_carry <= 1'b0;
    end else if (i_step) begin
      {o_carry, r_acc} <= {1'b0, r_acc} + {1'b0, i_frac};
    end
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample/bit tick generator with run-time divisor applied on period boundaries.
// Define BAUD_GEN_FRAC_EN to enable the fractional divisor accumulator.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FRAC_W       = DEF_FRAC_W,
  parameter int OVERSAMPLING = 16,
  parameter int DEF_DIV_INT  = int'(DEF_DIV.div_int),
  parameter int DEF_DIV_FRAC = int'(DEF_DIV.div_frac)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_wr,
  output logic              cfg_pending,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              baud_clk
);
  localparam int OS_W = OVERSAMPLING > 1 ? $clog2(OVERSAMPLING) : 1;
  logic [CNT_W-1:0] r_cnt, r_int_act, r_int_shd;
  logic [OS_W-1:0]  r_os_cnt;
  logic [CNT_W:0]   w_div_eff;
  logic             w_ext, w_term, w_last;
  assign w_div_eff = (r_int_act < CNT_W'(DIV_MIN) ? (CNT_W+1)'(DIV_MIN) : {1'b0, r_int_act})
                     + {{CNT_W{1'b0}}, w_ext};
  assign w_term = en && ({1'b0, r_cnt} == w_div_eff - 1'b1);
  assign w_last = r_os_cnt == OS_W'(OVERSAMPLING - 1);
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt <= '0;
      r_os_cnt <= '0;
      r_int_act <= CNT_W'(DEF_DIV_INT);
      r_int_shd <= '0;
      cfg_pending <= 1'b0;
      os_tick <= 1'b0;
      bit_tick <= 1'b0;
      baud_clk <= 1'b0;
    end else if (!en) begin
      r_cnt <= '0;
      r_os_cnt <= '0;
      os_tick <= 1'b0;
      bit_tick <= 1'b0;
      if (div_wr) begin
        r_int_act <= div_int;
        cfg_pending <= 1'b0;
      end
    end else begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
      os_tick <= w_term;
      bit_tick <= w_term && w_last;
      if (w_term) begin
        baud_clk <= ~baud_clk;
        r_os_cnt <= w_last ? '0 : r_os_cnt + 1'b1;
      end
      // a write landing on a terminal edge stays pending for the following boundary
      if (div_wr) begin
        r_int_shd <= div_int;
        cfg_pending <= 1'b1;
      end else if (w_term && cfg_pending) begin
        cfg_pending <= 1'b0;
      end
      if (w_term && cfg_pending) r_int_act <= r_int_shd;
    end
`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] r_frac_act, r_frac_shd;
  always_ff @(posedge clk)
    if (rst) begin
      r_frac_act <= FRAC_W'(DEF_DIV_FRAC);
      r_frac_shd <= '0;
    end else if (!en) begin
      if (div_wr) r_frac_act <= div_frac;
    end else begin
      if (div_wr) r_frac_shd <= div_frac;
      if (w_term && cfg_pending) r_frac_act <= r_frac_shd;
    end
  baud_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!en || (w_term && cfg_pending)),
    .i_step  (w_term),
    .i_frac  (r_frac_act),
    .o_carry (w_ext)
  );
`else
  logic w_unused;
  assign w_unused = ^{div_frac, FRAC_W'(DEF_DIV_FRAC)};
  assign w_ext = 1'b0;
`endif
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: scoreboard bench; stimulus queues expected tick periods, a monitor checks each os_tick.
module tb_uart_baud_gen;
`ifdef BAUD_GEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  localparam int OS = 16;
  localparam int FW = 4;
  typedef struct {
    int per;
    bit bt;
    bit bc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, div_wr = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic cfg_pending, os_tick, bit_tick, baud_clk;
  logic os1_pend, os1_os, os1_bit, os1_baud;
  exp_t q[$];
  int n_vec = 0, n_fail = 0;
  int m_acc = 0, m_ext = 0, m_os = 0;
  bit m_baud = 1'b0;
  always #5 clk = ~clk;
  uart_baud_gen #(.OVERSAMPLING(OS)) dut (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac), .div_wr(div_wr),
    .cfg_pending(cfg_pending), .os_tick(os_tick), .bit_tick(bit_tick), .baud_clk(baud_clk)
  );
  uart_baud_gen #(.OVERSAMPLING(1)) dut_os1 (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac), .div_wr(div_wr),
    .cfg_pending(os1_pend), .os_tick(os1_os), .bit_tick(os1_bit), .baud_clk(os1_baud)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(int n, int dint, int dfrac, bit rs_os, bit rs_acc);
    int d, s;
    d = dint < 2 ? 2 : dint;
    if (rs_os) m_os = 0;
    if (rs_acc) begin
      m_acc = 0;
      m_ext = 0;
    end
    for (int i = 0; i < n; i++) begin
      m_baud = !m_baud;
      q.push_back('{d + m_ext, m_os == OS - 1, m_baud});
      m_os = (m_os == OS - 1) ? 0 : m_os + 1;
      if (FRAC_ON) begin
        s = m_acc + dfrac;
        m_ext = s >> FW;
        m_acc = s % (1 << FW);
      end
    end
  endtask
  task automatic drain(int left, int budget);
    while (q.size() > left && budget > 0) begin
      step(1);
      budget--;
    end
    if (q.size() > left) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d queued expected %0d", q.size(), left);
      q.delete();
    end
  endtask
  task automatic wr_idle(int dint, int dfrac);
    en = 1'b0;
    div_wr = 1'b1;
    div_int = 16'(dint);
    div_frac = 4'(dfrac);
    step(1);
    div_wr = 1'b0;
    chk("pending_idle_wr", 32'(cfg_pending), 0);
  endtask
  initial begin : monitor
    int since;
    bit act;
    exp_t e;
    since = 0;
    act = 1'b0;
    forever begin
      @(negedge clk);
      since = act ? since + 1 : 0;
      chk("os1_vs_main", {os1_os, os1_bit, os1_baud, os1_pend, bit_tick & ~os_tick},
          {os_tick, os_tick, baud_clk, cfg_pending, 1'b0});
      if (os_tick) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", 32'(since), 0);
        end else begin
          e = q.pop_front();
          chk("period", 32'(since), 32'(e.per));
          chk("bit_tick", 32'(bit_tick), 32'(e.bt));
          chk("baud_clk", 32'(baud_clk), 32'(e.bc));
        end
        since = 0;
      end
      act = !rst && en;
    end
  end
  initial begin
    step(2);
    chk("rst_os_tick", 32'(os_tick), 0);
    chk("rst_bit_tick", 32'(bit_tick), 0);
    chk("rst_baud_clk", 32'(baud_clk), 0);
    chk("rst_pending", 32'(cfg_pending), 0);
    rst = 1'b0;
    en = 1'b1;
    push(17, 325, 8, 1, 1);
    drain(0, 6000);
    wr_idle(0, 0);
    en = 1'b1;
    push(4, 0, 0, 1, 1);
    drain(0, 50);
    wr_idle(1, 0);
    en = 1'b1;
    push(4, 1, 0, 1, 1);
    drain(0, 50);
    wr_idle(10, 8);
    en = 1'b1;
    push(32, 10, 8, 1, 1);
    drain(0, 500);
    wr_idle(100, 0);
    en = 1'b1;
    push(1, 100, 0, 1, 1);
    push(3, 30, 0, 0, 1);
    step(40);
    div_wr = 1'b1;
    div_int = 16'd20;
    step(1);
    div_wr = 1'b0;
    chk("pending_set", 32'(cfg_pending), 1);
    step(19);
    div_wr = 1'b1;
    div_int = 16'd30;
    step(1);
    div_wr = 1'b0;
    chk("pending_hold", 32'(cfg_pending), 1);
    drain(3, 100);
    chk("pending_clr", 32'(cfg_pending), 0);
    drain(0, 200);
    wr_idle(100, 0);
    en = 1'b1;
    step(50);
    en = 1'b0;
    step(3);
    en = 1'b1;
    push(16, 100, 0, 1, 1);
    drain(0, 2000);
    wr_idle(40, 0);
    en = 1'b1;
    step(20);
    div_wr = 1'b1;
    div_int = 16'd60;
    step(1);
    div_wr = 1'b0;
    chk("pending_pre_rst", 32'(cfg_pending), 1);
    step(9);
    rst = 1'b1;
    step(1);
    chk("midrst_os_tick", 32'(os_tick), 0);
    chk("midrst_bit_tick", 32'(bit_tick), 0);
    chk("midrst_baud_clk", 32'(baud_clk), 0);
    chk("midrst_pending", 32'(cfg_pending), 0);
    rst = 1'b0;
    m_baud = 1'b0;
    push(2, 325, 8, 1, 1);
    drain(0, 1000);
    en = 1'b0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
